// File: rtl/mfcc_pkg.sv
// Shared constants, state encoding and address-width helper for the
// MFCC frame buffer and its RAM.
package mfcc_pkg;

    localparam int MFCC_DATA_W     = 16;
    localparam int MFCC_NUM_COEFFS = 13;
    localparam int KWS_NUM_FRAMES  = 49;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } fb_state_t;

    // Address width of a ring of (frames+1) slots of 'coeffs' words each.
    function automatic int fb_addr_w(input int frames, input int coeffs);
        int w;
        w = $clog2((frames + 1) * coeffs);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int MFCC_FB_ADDR_W = fb_addr_w(KWS_NUM_FRAMES, MFCC_NUM_COEFFS);

endpackage

// File: rtl/mfcc_frame_buffer_if.sv
// Valid/ready stream carrying window elements to the keyword classifier.
interface mfcc_frame_buffer_if
    import mfcc_pkg::*;
#(
    parameter int DATA_W = MFCC_DATA_W
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              first;
    logic              last;

    modport master (output data, valid, first, last, input ready);
    modport slave  (input data, valid, first, last, output ready);
endinterface

// File: rtl/mfcc_fb_ram.sv
// Simple dual-port frame RAM: one write port, one read port with a
// registered output (1-cycle read latency). Contents are not reset.
module mfcc_fb_ram
    import mfcc_pkg::*;
#(
    parameter int DATA_W = MFCC_DATA_W,
    parameter int DEPTH  = (KWS_NUM_FRAMES + 1) * MFCC_NUM_COEFFS,
    parameter int ADDR_W = MFCC_FB_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mfcc_frame_buffer.sv
// Sliding-window frame buffer: collects MFCC coefficients into frames in a
// ring of NUM_FRAMES+1 slots and streams the latest NUM_FRAMES frames
// (oldest first) every STRIDE committed frames. The spare slot absorbs the
// incoming frame while a window streams out; frames completing mid-stream
// are dropped and flagged by the sticky overrun bit.
module mfcc_frame_buffer
    import mfcc_pkg::*;
#(
    parameter int DATA_W     = MFCC_DATA_W,
    parameter int NUM_COEFFS = MFCC_NUM_COEFFS,
    parameter int NUM_FRAMES = KWS_NUM_FRAMES,
    parameter int STRIDE     = 1,
    localparam int FS_W      = $clog2(NUM_FRAMES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   mfcc_feature,
    input  logic                mfcc_valid,
    input  logic                frame_clear,
    mfcc_frame_buffer_if.master feat,
    output logic [FS_W-1:0]     frames_stored,
    output logic                overrun
);

    localparam int SLOTS  = NUM_FRAMES + 1;
    localparam int DEPTH  = SLOTS * NUM_COEFFS;
    localparam int ADDR_W = fb_addr_w(NUM_FRAMES, NUM_COEFFS);
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int COEF_W = (NUM_COEFFS > 1) ? $clog2(NUM_COEFFS) : 1;
    localparam int TOTAL  = NUM_FRAMES * NUM_COEFFS;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int STR_W  = $clog2(STRIDE + 1);

    localparam logic [SLOT_W-1:0] SLOT_MAX  = SLOT_W'(NUM_FRAMES);
    localparam logic [COEF_W-1:0] COEF_LAST = COEF_W'(NUM_COEFFS - 1);
    localparam logic [FS_W-1:0]   FS_FULL   = FS_W'(NUM_FRAMES);
    localparam logic [STR_W-1:0]  STR_TOP   = STR_W'(STRIDE);
    localparam logic [CNT_W-1:0]  CNT_TOTAL = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TOTAL - 1);

    // Ring successor of a slot index.
    function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
        return (s == SLOT_MAX) ? '0 : s + 1'b1;
    endfunction

    fb_state_t state_reg, state_next;

    // Write side
    logic [COEF_W-1:0] coef_reg;
    logic [SLOT_W-1:0] wr_slot_reg;
    logic [FS_W-1:0]   frames_stored_reg;
    logic [STR_W-1:0]  stride_reg;
    logic              overrun_reg;

    // Read sequencer
    logic [SLOT_W-1:0] rd_slot_reg;
    logic [COEF_W-1:0] rd_coef_reg;
    logic [CNT_W-1:0]  issue_cnt_reg;
    logic              rd_valid_reg, rd_first_reg, rd_last_reg;
    logic [DATA_W-1:0] ram_rdata;

    // Skid and output registers
    logic              skid_valid_reg, skid_first_reg, skid_last_reg;
    logic [DATA_W-1:0] skid_data_reg;
    logic              out_valid_reg, out_first_reg, out_last_reg;
    logic [DATA_W-1:0] out_data_reg;

    logic              wr_en, frame_done, accept, final_accept;
    logic              commit, drop, start, issue_stream, read_en;
    logic [SLOT_W-1:0] wr_slot_inc, issue_slot;
    logic [COEF_W-1:0] issue_coef;
    logic [CNT_W-1:0]  issue_idx;
    logic [FS_W-1:0]   stored_inc;
    logic [STR_W-1:0]  stride_inc;
    logic [1:0]        fill;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    // A clear discards any coefficient arriving in the same cycle.
    assign wr_en        = mfcc_valid & ~frame_clear;
    assign frame_done   = wr_en & (coef_reg == COEF_LAST);
    assign accept       = out_valid_reg & feat.ready;
    assign final_accept = (state_reg == STREAM) & accept & out_last_reg;

    // A frame may only take the spare slot when no window is reading it.
    assign commit = frame_done & ((state_reg == IDLE) | final_accept);
    assign drop   = frame_done & ~commit;

    assign wr_slot_inc = slot_inc(wr_slot_reg);
    assign stored_inc  = (frames_stored_reg == FS_FULL) ? FS_FULL : frames_stored_reg + 1'b1;
    // The stride counter saturates so the first window leaves as soon as
    // the buffer fills, then every STRIDE frames after that.
    assign stride_inc  = (stride_reg == STR_TOP) ? STR_TOP : stride_reg + 1'b1;
    assign start       = commit & (stored_inc == FS_FULL) & (stride_inc == STR_TOP);

    // Elements held or in flight after this cycle's handshake; a new read
    // is only issued if its data is guaranteed a place (output or skid).
    assign fill = 2'(out_valid_reg) + 2'(skid_valid_reg) + 2'(rd_valid_reg) - 2'(accept);
    assign issue_stream = (state_reg == STREAM) & (issue_cnt_reg != CNT_TOTAL) & (fill <= 2'd1);
    assign read_en      = (start | issue_stream) & ~frame_clear;

    // The first read of a window is issued in the commit cycle itself,
    // from the slot just past the new write slot (the oldest frame).
    always_comb begin
        issue_slot = rd_slot_reg;
        issue_coef = rd_coef_reg;
        issue_idx  = issue_cnt_reg;
        if (start) begin
            issue_slot = slot_inc(wr_slot_inc);
            issue_coef = '0;
            issue_idx  = '0;
        end
    end

    assign wr_addr = ADDR_W'(wr_slot_reg) * ADDR_W'(NUM_COEFFS) + ADDR_W'(coef_reg);
    assign rd_addr = ADDR_W'(issue_slot)  * ADDR_W'(NUM_COEFFS) + ADDR_W'(issue_coef);

    mfcc_fb_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (mfcc_feature),
        .re    (read_en),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state; a commit on the last accepted element may start the
    // next window straight away.
    always_comb begin
        state_next = state_reg;
        if (frame_clear) begin
            state_next = IDLE;
        end else if (start) begin
            state_next = STREAM;
        end else if (final_accept) begin
            state_next = IDLE;
        end
    end

    // Write pointer, fill level, stride counter and sticky overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coef_reg          <= '0;
            wr_slot_reg       <= '0;
            frames_stored_reg <= '0;
            stride_reg        <= '0;
            overrun_reg       <= 1'b0;
        end else if (frame_clear) begin
            coef_reg          <= '0;
            wr_slot_reg       <= '0;
            frames_stored_reg <= '0;
            stride_reg        <= '0;
            overrun_reg       <= 1'b0;
        end else begin
            if (wr_en) begin
                coef_reg <= frame_done ? '0 : coef_reg + 1'b1;
            end
            if (commit) begin
                wr_slot_reg       <= wr_slot_inc;
                frames_stored_reg <= stored_inc;
                stride_reg        <= start ? '0 : stride_inc;
            end
            if (drop) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // Read address sequencer and tags travelling alongside the RAM output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_slot_reg   <= '0;
            rd_coef_reg   <= '0;
            issue_cnt_reg <= '0;
            rd_valid_reg  <= 1'b0;
            rd_first_reg  <= 1'b0;
            rd_last_reg   <= 1'b0;
        end else if (frame_clear) begin
            rd_slot_reg   <= '0;
            rd_coef_reg   <= '0;
            issue_cnt_reg <= '0;
            rd_valid_reg  <= 1'b0;
            rd_first_reg  <= 1'b0;
            rd_last_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= read_en;
            if (read_en) begin
                rd_first_reg  <= (issue_idx == '0);
                rd_last_reg   <= (issue_idx == CNT_LAST);
                issue_cnt_reg <= issue_idx + 1'b1;
                if (issue_coef == COEF_LAST) begin
                    rd_coef_reg <= '0;
                    rd_slot_reg <= slot_inc(issue_slot);
                end else begin
                    rd_coef_reg <= issue_coef + 1'b1;
                    rd_slot_reg <= issue_slot;
                end
            end
        end
    end

    // Output register with a one-entry skid: the skid always holds the
    // older element, so it refills the output before fresh RAM data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_first_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_first_reg <= 1'b0;
            skid_last_reg  <= 1'b0;
        end else if (frame_clear) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_first_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_first_reg <= 1'b0;
            skid_last_reg  <= 1'b0;
        end else if (!out_valid_reg || feat.ready) begin
            if (skid_valid_reg) begin
                out_valid_reg  <= 1'b1;
                out_data_reg   <= skid_data_reg;
                out_first_reg  <= skid_first_reg;
                out_last_reg   <= skid_last_reg;
                skid_valid_reg <= rd_valid_reg;
                skid_data_reg  <= ram_rdata;
                skid_first_reg <= rd_first_reg;
                skid_last_reg  <= rd_last_reg;
            end else if (rd_valid_reg) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= ram_rdata;
                out_first_reg <= rd_first_reg;
                out_last_reg  <= rd_last_reg;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end else if (rd_valid_reg) begin
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= ram_rdata;
            skid_first_reg <= rd_first_reg;
            skid_last_reg  <= rd_last_reg;
        end
    end

    assign feat.valid    = out_valid_reg;
    assign feat.data     = out_data_reg;
    assign feat.first    = out_first_reg;
    assign feat.last     = out_last_reg;
    assign frames_stored = frames_stored_reg;
    assign overrun       = overrun_reg;

endmodule
